// File: rtl/sp_ram_sync_if.sv
// sp_ram_sync_if: access bus of the sp_ram_sync scratch RAM.
// Master issues requests; slave returns read data and status.
interface sp_ram_sync_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic                CS;
   logic                WR;
   logic                RD;
   logic [ADDR_W-1:0]   ADDR;
   logic [DATA_W-1:0]   DATA_IN;
   logic [DATA_W/8-1:0] BE;
   logic [DATA_W-1:0]   DATA_OUT;
   logic                RD_VALID;
   logic                BUSY;
   logic                ERR;

   modport master (
      output CS, WR, RD, ADDR, DATA_IN, BE,
      input  DATA_OUT, RD_VALID, BUSY, ERR
   );

   modport slave (
      input  CS, WR, RD, ADDR, DATA_IN, BE,
      output DATA_OUT, RD_VALID, BUSY, ERR
   );
endinterface

// File: rtl/sp_ram_sync.sv
// sp_ram_sync: synchronous single-port RAM, byte enables, clear sweep.
// Define RAM_OUT_REG_EN to add an output register stage (latency 2).
module sp_ram_sync #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 10,
   parameter int                DEPTH    = 1024,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic         CLK,
   input  logic         RST,
   sp_ram_sync_if.slave bus
);

   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rdv_q, rdv_d;
   logic              err_q, err_d;

   logic              req;
   logic              in_rng;
   logic              wr_en;
   logic              clr_en;
   logic [IW-1:0]     a_idx;
   logic [IW-1:0]     c_idx;

   assign req    = bus.CS && (bus.WR || bus.RD);
   assign in_rng = ({1'b0, bus.ADDR} < (ADDR_W+1)'(DEPTH));
   assign a_idx  = bus.ADDR[IW-1:0];
   assign c_idx  = cnt_q[IW-1:0];

   // next state, sweep counter and access decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rdv_d   = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      clr_en  = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_en = 1'b1;
            err_d  = req;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_RUN: begin
            if (req) begin
               if (!in_rng) begin
                  err_d = 1'b1;
                  if (!bus.WR) begin
                     rdv_d  = 1'b1;
                     dout_d = '0;
                  end
               end else if (bus.WR) begin
                  wr_en = 1'b1;
               end else begin
                  rdv_d  = 1'b1;
                  dout_d = mem[a_idx];
               end
            end
         end
      endcase
   end

   // state, sweep counter and first output stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         dout_q  <= '0;
         rdv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rdv_q   <= rdv_d;
         err_q   <= err_d;
      end
   end

   // storage: sweep writes INIT_VAL, accesses write enabled bytes
   always_ff @(posedge CLK) begin
      if (clr_en) begin
         mem[c_idx] <= INIT_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.BE[i]) begin
               mem[a_idx][8*i +: 8] <= bus.DATA_IN[8*i +: 8];
            end
         end
      end
   end

`ifdef RAM_OUT_REG_EN
   logic [DATA_W-1:0] dout2_q;
   logic              rdv2_q;
   logic              err2_q;

   // extra output stage keeping data, valid and error aligned
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dout2_q <= '0;
         rdv2_q  <= 1'b0;
         err2_q  <= 1'b0;
      end else begin
         dout2_q <= dout_q;
         rdv2_q  <= rdv_q;
         err2_q  <= err_q;
      end
   end

   assign bus.DATA_OUT = dout2_q;
   assign bus.RD_VALID = rdv2_q;
   assign bus.ERR      = err2_q;
`else
   assign bus.DATA_OUT = dout_q;
   assign bus.RD_VALID = rdv_q;
   assign bus.ERR      = err_q;
`endif

   assign bus.BUSY = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sp_ram_sync.sv
// tb_sp_ram_sync: scoreboard bench for sp_ram_sync.
// Reference memory model plus queue of expected output events.
module tb_sp_ram_sync;

   localparam int          DEPTH = 1000;
   localparam logic [15:0] INIT  = 16'hA5A5;
`ifdef RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int          cyc;
      bit          rv;
      bit          err;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   mbusy = 1'b1;
   logic [15:0] hold = '0;
   logic [15:0] model [DEPTH];
   exp_t sb [$];

   sp_ram_sync_if #(.DATA_W(16), .ADDR_W(10)) bus ();

   sp_ram_sync #(
      .DATA_W  (16),
      .ADDR_W  (10),
      .DEPTH   (DEPTH),
      .INIT_VAL(INIT)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic push(bit rv, bit err, logic [15:0] d);
      exp_t e;
      e.cyc  = cyc + LAT;
      e.rv   = rv;
      e.err  = err;
      e.data = d;
      sb.push_back(e);
   endtask

   // drive one request and record what the RAM must answer
   task automatic issue(bit cs, bit wr, bit rd, logic [9:0] a,
                        logic [15:0] d, logic [1:0] be);
      bus.CS      = cs;
      bus.WR      = wr;
      bus.RD      = rd;
      bus.ADDR    = a;
      bus.DATA_IN = d;
      bus.BE      = be;
      if (cs && (wr || rd)) begin
         if (mbusy) begin
            push(1'b0, 1'b1, '0);
         end else if (wr) begin
            if (int'(a) < DEPTH) begin
               for (int b = 0; b < 2; b++)
                  if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
            end else begin
               push(1'b0, 1'b1, '0);
            end
         end else if (int'(a) < DEPTH) begin
            push(1'b1, 1'b0, model[a]);
         end else begin
            push(1'b1, 1'b1, '0);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         issue(1'b1, 1'b0, 1'b1, 10'(a), 16'($urandom), 2'($urandom));
         step();
      end
      idle();
   endtask

   // assert reset, check reset outputs, then time the clear sweep
   task automatic reset_sweep();
      int n;
      rst = 1'b1;
      idle();
      sb.delete();
      hold = '0;
      #1;
      chk("rst_data_out", 32'(bus.DATA_OUT), 0);
      chk("rst_rd_valid", 32'(bus.RD_VALID), 0);
      chk("rst_err", 32'(bus.ERR), 0);
      chk("rst_busy", 32'(bus.BUSY), 1);
      repeat (2) step();
      rst   = 1'b0;
      mbusy = 1'b1;
      for (int a = 0; a < DEPTH; a++) model[a] = INIT;
      n = 0;
      for (int i = 1; i <= 2 * DEPTH; i++) begin
         if (i == 3)
            issue(1'b1, 1'b0, 1'b1, 10'($urandom % DEPTH), '0, 2'b11);
         else if (i == 5)
            issue(1'b1, 1'b1, 1'b0, 10'd7, 16'hDEAD, 2'b11);
         else
            idle();
         step();
         n++;
         if (!bus.BUSY) break;
      end
      mbusy = 1'b0;
      idle();
      chk("sweep_len", 32'(n), 32'(DEPTH));
   endtask

   // monitor: compare every presented output against the queue
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.RD_VALID || bus.ERR) begin
            if (sb.size() == 0) begin
               chk("unexpected_out",
                   {30'd0, bus.RD_VALID, bus.ERR}, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_cycle", 32'(cyc), 32'(e.cyc));
               chk("rd_valid", 32'(bus.RD_VALID), 32'(e.rv));
               chk("err", 32'(bus.ERR), 32'(e.err));
               if (e.rv) begin
                  chk("rd_data", 32'(bus.DATA_OUT), 32'(e.data));
                  hold = e.data;
               end
            end
         end else begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               chk("missing_out", 32'(sb[0].cyc), 32'(-1));
               void'(sb.pop_front());
            end
            chk("data_hold", 32'(bus.DATA_OUT), 32'(hold));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      step();
      reset_sweep();
      read_all();

      issue(1'b1, 1'b1, 1'b0, 10'd5, 16'h1234, 2'b11);
      step();
      issue(1'b1, 1'b1, 1'b0, 10'd5, 16'hABCD, 2'b10);
      step();
      issue(1'b1, 1'b1, 1'b0, 10'd5, 16'hFFFF, 2'b00);
      step();
      issue(1'b1, 1'b0, 1'b1, 10'd5, '0, '0);
      step();
      idle();
      repeat (LAT) step();
      chk("be_merge", 32'(bus.DATA_OUT), 32'h0000AB34);

      issue(1'b1, 1'b1, 1'b1, 10'd3, 16'h00FF, 2'b11);
      step();
      issue(1'b1, 1'b0, 1'b1, 10'd3, '0, '0);
      step();
      idle();
      repeat (LAT) step();
      chk("write_first", 32'(bus.DATA_OUT), 32'h000000FF);

      issue(1'b1, 1'b1, 1'b0, 10'd999, 16'h1111, 2'b11);
      step();
      issue(1'b1, 1'b1, 1'b0, 10'd1000, 16'h2222, 2'b11);
      step();
      issue(1'b1, 1'b0, 1'b1, 10'd1000, '0, '0);
      step();
      issue(1'b1, 1'b0, 1'b1, 10'd999, '0, '0);
      step();
      idle();
      repeat (LAT) step();
      chk("range_keep_999", 32'(bus.DATA_OUT), 32'h00001111);

      for (int i = 0; i < 3000; i++) begin
         int sel;
         logic [9:0] a;
         sel = int'($urandom % 8);
         if (sel == 0)      a = 10'(1000 + $urandom % 24);
         else if (sel < 5)  a = 10'($urandom % 16);
         else               a = 10'($urandom % DEPTH);
         issue(($urandom % 16) != 0, 1'($urandom), 1'($urandom),
               a, 16'($urandom), 2'($urandom));
         step();
      end
      idle();
      repeat (LAT + 1) step();

      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 1'b0, 1'b1, 10'(i), '0, '0);
         step();
         if (i == 3) break;
      end
      reset_sweep();
      read_all();

      repeat (LAT + 2) step();
      chk("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
